// File: rtl/conv_11x11.sv
// conv_11x11: 11x11 symmetric-kernel convolution, 8-bit pixels, 18-bit result.
// Four register stages: symmetric pre-add, products, row sums, total.
// Optional macro CONV_NORM_EN: dout = (sum + 512) >> 10 for unity-gain kernels.
module conv_11x11 (
  input  logic        clk,
  input  logic        rst,
  input  logic [87:0] din1,
  input  logic [87:0] din2,
  input  logic [87:0] din3,
  input  logic [87:0] din4,
  input  logic [87:0] din5,
  input  logic [87:0] din6,
  input  logic [87:0] din7,
  input  logic [87:0] din8,
  input  logic [87:0] din9,
  input  logic [87:0] din10,
  input  logic [87:0] din11,
  input  logic [47:0] df1_1,
  input  logic [47:0] df1_2,
  input  logic [47:0] df1_3,
  input  logic [47:0] df1_4,
  input  logic [47:0] df1_5,
  input  logic [47:0] df1_6,
  input  logic [47:0] df1_7,
  input  logic [47:0] df1_8,
  input  logic [47:0] df1_9,
  input  logic [47:0] df1_10,
  input  logic [47:0] df1_11,
  output logic [17:0] dout,
  output logic        out_en
);

  logic [87:0] row_pix  [11];
  logic [47:0] row_coef [11];

  // Coefficients travel with their pixels so every result uses one consistent kernel.
  logic [8:0]  s1_pre  [11][5];
  logic [7:0]  s1_ctr  [11];
  logic [7:0]  s1_coef [11][6];
  logic [16:0] s2_prod [11][6];
  logic [17:0] s3_row  [11];
  logic [17:0] row_sum_c [11];
  logic [17:0] total_c;
  logic [17:0] dout_c;
  logic [3:0]  vld;

  assign row_pix[0]  = din1;
  assign row_pix[1]  = din2;
  assign row_pix[2]  = din3;
  assign row_pix[3]  = din4;
  assign row_pix[4]  = din5;
  assign row_pix[5]  = din6;
  assign row_pix[6]  = din7;
  assign row_pix[7]  = din8;
  assign row_pix[8]  = din9;
  assign row_pix[9]  = din10;
  assign row_pix[10] = din11;

  assign row_coef[0]  = df1_1;
  assign row_coef[1]  = df1_2;
  assign row_coef[2]  = df1_3;
  assign row_coef[3]  = df1_4;
  assign row_coef[4]  = df1_5;
  assign row_coef[5]  = df1_6;
  assign row_coef[6]  = df1_7;
  assign row_coef[7]  = df1_8;
  assign row_coef[8]  = df1_9;
  assign row_coef[9]  = df1_10;
  assign row_coef[10] = df1_11;

  // Stage 1: fold mirrored pixel pairs, keep centre pixel and kernel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 11; r++) begin
        for (int p = 0; p < 5; p++) s1_pre[r][p] <= '0;
        for (int j = 0; j < 6; j++) s1_coef[r][j] <= '0;
        s1_ctr[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 11; r++) begin
        for (int p = 0; p < 5; p++)
          s1_pre[r][p] <= {1'b0, row_pix[r][87-8*p -: 8]} + {1'b0, row_pix[r][7+8*p -: 8]};
        for (int j = 0; j < 6; j++) s1_coef[r][j] <= row_coef[r][47-8*j -: 8];
        s1_ctr[r] <= row_pix[r][47:40];
      end
    end
  end

  // Stage 2: one multiply per half-kernel tap, centre tap takes the bare pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 11; r++)
        for (int j = 0; j < 6; j++) s2_prod[r][j] <= '0;
    end else begin
      for (int r = 0; r < 11; r++) begin
        for (int j = 0; j < 5; j++)
          s2_prod[r][j] <= {8'b0, s1_pre[r][j]} * {9'b0, s1_coef[r][j]};
        s2_prod[r][5] <= {9'b0, s1_ctr[r]} * {9'b0, s1_coef[r][5]};
      end
    end
  end

  // Row sums of the six products, wrapping at 18 bits.
  always_comb begin
    for (int r = 0; r < 11; r++) begin
      row_sum_c[r] = '0;
      for (int j = 0; j < 6; j++) row_sum_c[r] = row_sum_c[r] + {1'b0, s2_prod[r][j]};
    end
  end

  // Stage 3: register row sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 11; r++) s3_row[r] <= '0;
    end else begin
      for (int r = 0; r < 11; r++) s3_row[r] <= row_sum_c[r];
    end
  end

`ifdef CONV_NORM_EN
  logic [18:0] rnd_c;
`endif

  // Final total, optionally rounded and scaled down by 1024.
  always_comb begin
    total_c = '0;
    for (int r = 0; r < 11; r++) total_c = total_c + s3_row[r];
`ifdef CONV_NORM_EN
    rnd_c  = {1'b0, total_c} + 19'd512;
    dout_c = 18'(rnd_c >> 10);
`else
    dout_c = total_c;
`endif
  end

  // Stage 4: output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= '0;
    else     dout <= dout_c;
  end

  // Valid pipe fills with ones after reset release; matches the four data stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= {vld[2:0], 1'b1};
  end

  assign out_en = vld[3];

endmodule

// File: tb/tb_conv_11x11.sv
// Testbench for conv_11x11: directed kernels/patterns plus random streaming,
// checked against a direct sum-of-products model of the full 11x11 window.
module tb_conv_11x11;

  logic        clk;
  logic        rst;
  logic [87:0] din [11];
  logic [47:0] df  [11];
  logic [17:0] dout;
  logic        out_en;

  int errors = 0;
  int checks = 0;

  logic [7:0]  pix  [11][11];
  logic [47:0] kern [11];
  int          exp_q [$];

  conv_11x11 dut (
    .clk(clk), .rst(rst),
    .din1(din[0]), .din2(din[1]), .din3(din[2]), .din4(din[3]), .din5(din[4]),
    .din6(din[5]), .din7(din[6]), .din8(din[7]), .din9(din[8]), .din10(din[9]),
    .din11(din[10]),
    .df1_1(df[0]), .df1_2(df[1]), .df1_3(df[2]), .df1_4(df[3]), .df1_5(df[4]),
    .df1_6(df[5]), .df1_7(df[6]), .df1_8(df[7]), .df1_9(df[8]), .df1_10(df[9]),
    .df1_11(df[10]),
    .dout(dout), .out_en(out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int weight(int r, int p);
    int j;
    j = (p <= 5) ? p : 10 - p;
    return int'(kern[r][47-8*j -: 8]);
  endfunction

  // Expected dout for the current window held in pix.
  function automatic int model();
    int sum;
    sum = 0;
    for (int r = 0; r < 11; r++)
      for (int p = 0; p < 11; p++)
        sum += int'(pix[r][p]) * weight(r, p);
    sum = sum % 262144;
`ifdef CONV_NORM_EN
    sum = (sum + 512) / 1024;
`endif
    return sum;
  endfunction

  task automatic drive();
    for (int r = 0; r < 11; r++) begin
      for (int p = 0; p < 11; p++) din[r][87-8*p -: 8] = pix[r][p];
      df[r] = kern[r];
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 11; r++)
      for (int p = 0; p < 11; p++) pix[r][p] = v;
    drive();
  endtask

  task automatic randomize_rows(input bit all_rows);
    for (int r = 0; r < 11; r++)
      if (all_rows || r == 0 || r == 5 || r == 7)
        for (int p = 0; p < 11; p++) pix[r][p] = 8'($urandom);
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  int e;

  initial begin
    kern[0] = 48'h00_00_01_01_02_02;
    kern[1] = 48'h00_01_02_03_05_06;
    kern[2] = 48'h01_02_04_08_0c_0d;
    kern[3] = 48'h01_03_08_0f_16_19;
    kern[4] = 48'h02_05_0c_16_20_24;
    kern[5] = 48'h02_06_0d_19_24_29;
    for (int r = 6; r < 11; r++) kern[r] = kern[10-r];

    // Reset held with random inputs: outputs stay zero.
    rst = 1'b1;
    randomize_rows(1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      randomize_rows(1'b1);
      chk("reset_dout", int'(dout), 0);
      chk("reset_out_en", int'(out_en), 0);
    end

    // Flat 0x11 after release: out_en rises on the 4th edge.
    fill(8'h11);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("fill_out_en_low", int'(out_en), 0);
    end
    step();
    chk("fill_out_en_high", int'(out_en), 1);
`ifdef CONV_NORM_EN
    chk("flat_norm", int'(dout), 17);
`else
    chk("flat", int'(dout), 17425);
`endif
    chk("flat_model", int'(dout), model());

    // Max input, no wrap.
    fill(8'hFF);
    repeat (4) step();
`ifdef CONV_NORM_EN
    chk("max_norm", int'(dout), 255);
`else
    chk("max", int'(dout), 261375);
`endif
    chk("max_model", int'(dout), model());

    // Mirrored pair in row 6.
    fill(8'h00);
    pix[5][1] = 8'h01;
    pix[5][9] = 8'h01;
    drive();
    repeat (4) step();
    chk("symmetry", int'(dout), model());
`ifndef CONV_NORM_EN
    chk("symmetry_const", int'(dout), 12);
`endif

    // Centre tap only.
    fill(8'h00);
    pix[5][5] = 8'h01;
    drive();
    repeat (4) step();
    chk("centre", int'(dout), model());
`ifndef CONV_NORM_EN
    chk("centre_const", int'(dout), 41);
`endif

    // Streaming: new pattern every cycle on rows 1/6/8, one result per cycle.
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      randomize_rows(i < 20 ? 1'b0 : 1'b1);
      exp_q.push_back(model());
      step();
      if (exp_q.size() == 4) begin
        e = exp_q.pop_front();
        chk("stream_dout", int'(dout), e);
        chk("stream_out_en", int'(out_en), 1);
      end
    end

    // Mid-stream reset: outputs clear between edges, then the fill repeats.
    randomize_rows(1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_dout", int'(dout), 0);
    chk("async_rst_out_en", int'(out_en), 0);
    step();
    randomize_rows(1'b1);
    step();
    chk("held_rst_out_en", int'(out_en), 0);
    randomize_rows(1'b1);
    e = model();
    rst = 1'b0;
    step();
    chk("refill_out_en_1", int'(out_en), 0);
    randomize_rows(1'b1);
    step();
    chk("refill_out_en_2", int'(out_en), 0);
    step();
    chk("refill_out_en_3", int'(out_en), 0);
    chk("refill_dout_pre", int'(dout), 0);
    step();
    chk("refill_out_en_4", int'(out_en), 1);
    chk("refill_dout", int'(dout), e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
